// File: rtl/execute_stage_pkg.sv
// Shared types for the rvga execute stage: word/register widths, ALU opcodes, FSM states.
package rvga_types;

  localparam int RVGA_WORD = 32;
  localparam int RVGA_REG  = 5;

  typedef logic [RVGA_WORD-1:0] rvga_word_t;
  typedef logic [RVGA_REG-1:0]  rvga_reg_t;

  // Values follow the RISC-V funct3 encoding so decode can pass funct3 straight through
  typedef enum logic [2:0] {
    ART_ADD  = 3'd0,
    ART_SLL  = 3'd1,
    ART_SLT  = 3'd2,
    ART_SLTU = 3'd3,
    ART_XOR  = 3'd4,
    ART_SRL  = 3'd5,
    ART_OR   = 3'd6,
    ART_AND  = 3'd7
  } rvga_artop_e;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } exec_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// Register-fetch -> execute -> memory/fetch signal bundle; master is the register-fetch side.
interface execute_stage_if import rvga_types::*; ();

  logic       rfetch_execute_v;
  rvga_word_t rfetch_execute_pc;
  rvga_reg_t  rfetch_execute_rd;
  logic       rfetch_execute_rd_w_v;
  logic       rfetch_execute_pc_w_v;
  rvga_word_t rfetch_execute_rs1_data;
  rvga_word_t rfetch_execute_rs2_data;
  rvga_word_t rfetch_execute_imm_data;
  logic       rfetch_execute_imm_v;
  logic       rfetch_execute_imm_passthrough_v;
  logic       rfetch_execute_rs1_pc_sel;
  logic [2:0] rfetch_execute_artop;
  logic       rfetch_execute_alt_art;

  logic       execute_rfetch_stall;
  logic       execute_memory_v;
  rvga_word_t execute_memory_pc;
  rvga_reg_t  execute_memory_rd;
  logic       execute_memory_rd_w_v;
  rvga_word_t execute_memory_result;
  logic       execute_fetch_pc_w_v;
  rvga_word_t execute_fetch_pc;

  modport master (
    output rfetch_execute_v, rfetch_execute_pc, rfetch_execute_rd, rfetch_execute_rd_w_v,
           rfetch_execute_pc_w_v, rfetch_execute_rs1_data, rfetch_execute_rs2_data,
           rfetch_execute_imm_data, rfetch_execute_imm_v, rfetch_execute_imm_passthrough_v,
           rfetch_execute_rs1_pc_sel, rfetch_execute_artop, rfetch_execute_alt_art,
    input  execute_rfetch_stall, execute_memory_v, execute_memory_pc, execute_memory_rd,
           execute_memory_rd_w_v, execute_memory_result, execute_fetch_pc_w_v, execute_fetch_pc
  );

  modport slave (
    input  rfetch_execute_v, rfetch_execute_pc, rfetch_execute_rd, rfetch_execute_rd_w_v,
           rfetch_execute_pc_w_v, rfetch_execute_rs1_data, rfetch_execute_rs2_data,
           rfetch_execute_imm_data, rfetch_execute_imm_v, rfetch_execute_imm_passthrough_v,
           rfetch_execute_rs1_pc_sel, rfetch_execute_artop, rfetch_execute_alt_art,
    output execute_rfetch_stall, execute_memory_v, execute_memory_pc, execute_memory_rd,
           execute_memory_rd_w_v, execute_memory_result, execute_fetch_pc_w_v, execute_fetch_pc
  );

endinterface

// File: rtl/execute_stage_shifter.sv
// Serial 1-bit/cycle shifter: loads on start, shifts once per edge until the count reaches 0.
module rvga_serial_shifter import rvga_types::*; (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  rvga_word_t din,
  input  rvga_reg_t  shamt,
  input  logic       dir_right,
  input  logic       arith,
  output logic       busy,
  output logic       done,
  output rvga_word_t result
);

  rvga_word_t acc_p1;
  rvga_reg_t  cnt_p1;
  logic       right_p1;
  logic       arith_p1;
  rvga_word_t step;

  assign step   = right_p1 ? {arith_p1 & acc_p1[31], acc_p1[31:1]} : {acc_p1[30:0], 1'b0};
  assign busy   = (cnt_p1 != '0);
  assign done   = (cnt_p1 == 5'd1);
  // Presented during the last busy cycle so the owner captures it on the same edge cnt hits 0
  assign result = step;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_p1   <= '0;
      right_p1 <= 1'b0;
      arith_p1 <= 1'b0;
    end else if (start) begin
      cnt_p1   <= shamt;
      right_p1 <= dir_right;
      arith_p1 <= arith & dir_right;
    end else if (busy) begin
      cnt_p1   <= cnt_p1 - 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (start)     acc_p1 <= din;
    else if (busy) acc_p1 <= step;
  end

endmodule

// File: rtl/execute_stage.sv
// rvga integer execute stage: operand muxes, ALU, jump link/target and registered results.
module execute_stage import rvga_types::*; (
  input logic             clk,
  input logic             rst,
  execute_stage_if.slave  bus
);

  exec_state_e       state, state_nxt;
  rvga_artop_e       artop;
  rvga_word_t        op_a, op_b, alu_res, res_p0, target_p0, sh_result;
  logic signed [31:0] op_a_s, op_b_s;
  rvga_reg_t         shamt;
  logic              is_shift, take_short, shift_start, redirect_p0;
  logic              sh_busy, sh_done;

  rvga_word_t pc_hold;
  rvga_reg_t  rd_hold;
  logic       rd_w_hold;

  logic       mem_v_p1, mem_rd_w_v_p1, fetch_pc_w_v_p1;
  rvga_word_t mem_pc_p1, mem_result_p1, fetch_pc_p1;
  rvga_reg_t  mem_rd_p1;

  assign artop  = rvga_artop_e'(bus.rfetch_execute_artop);
  assign op_a   = bus.rfetch_execute_rs1_pc_sel ? bus.rfetch_execute_pc : bus.rfetch_execute_rs1_data;
  assign op_b   = bus.rfetch_execute_imm_v ? bus.rfetch_execute_imm_data : bus.rfetch_execute_rs2_data;
  assign op_a_s = signed'(op_a);
  assign op_b_s = signed'(op_b);
  assign shamt  = op_b[4:0];

  assign redirect_p0 = bus.rfetch_execute_pc_w_v && !bus.rfetch_execute_imm_passthrough_v;
  assign is_shift    = !bus.rfetch_execute_imm_passthrough_v && !bus.rfetch_execute_pc_w_v &&
                       (artop == ART_SLL || artop == ART_SRL);
  assign shift_start = (state == IDLE) && bus.rfetch_execute_v && is_shift && (shamt != '0);
  assign take_short  = (state == IDLE) && bus.rfetch_execute_v && !shift_start;

  always_comb begin
    alu_res = op_a;
    unique case (artop)
      ART_ADD:  alu_res = bus.rfetch_execute_alt_art ? op_a - op_b : op_a + op_b;
      ART_SLT:  alu_res = {31'b0, op_a_s < op_b_s};
      ART_SLTU: alu_res = {31'b0, op_a < op_b};
      ART_XOR:  alu_res = op_a ^ op_b;
      ART_OR:   alu_res = op_a | op_b;
      ART_AND:  alu_res = op_a & op_b;
      default:  alu_res = op_a;  // shift by zero
    endcase
  end

  assign res_p0    = bus.rfetch_execute_imm_passthrough_v ? bus.rfetch_execute_imm_data :
                     bus.rfetch_execute_pc_w_v ? bus.rfetch_execute_pc + 32'd4 : alu_res;
  assign target_p0 = (op_a + bus.rfetch_execute_imm_data) & ~32'd1;

  rvga_serial_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .start     (shift_start),
    .din       (op_a),
    .shamt     (shamt),
    .dir_right (artop == ART_SRL),
    .arith     (bus.rfetch_execute_alt_art),
    .busy      (sh_busy),
    .done      (sh_done),
    .result    (sh_result)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (shift_start) state_nxt = SHIFT;
      SHIFT:   if (sh_done || !sh_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.execute_rfetch_stall = (state == SHIFT);

  // p0 -> p1: destination fields captured at shift acceptance, since inputs are ignored in SHIFT
  always_ff @(posedge clk) begin
    if (shift_start) begin
      pc_hold   <= bus.rfetch_execute_pc;
      rd_hold   <= bus.rfetch_execute_rd;
      rd_w_hold <= bus.rfetch_execute_rd_w_v && (bus.rfetch_execute_rd != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_v_p1        <= 1'b0;
      mem_pc_p1       <= '0;
      mem_rd_p1       <= '0;
      mem_rd_w_v_p1   <= 1'b0;
      mem_result_p1   <= '0;
      fetch_pc_w_v_p1 <= 1'b0;
      fetch_pc_p1     <= '0;
    end else begin
      mem_v_p1        <= 1'b0;
      fetch_pc_w_v_p1 <= 1'b0;
      if (take_short) begin
        mem_v_p1        <= 1'b1;
        mem_pc_p1       <= bus.rfetch_execute_pc;
        mem_rd_p1       <= bus.rfetch_execute_rd;
        mem_rd_w_v_p1   <= bus.rfetch_execute_rd_w_v && (bus.rfetch_execute_rd != '0);
        mem_result_p1   <= res_p0;
        fetch_pc_w_v_p1 <= redirect_p0;
        if (redirect_p0) fetch_pc_p1 <= target_p0;
      end else if (state == SHIFT && sh_done) begin
        mem_v_p1      <= 1'b1;
        mem_pc_p1     <= pc_hold;
        mem_rd_p1     <= rd_hold;
        mem_rd_w_v_p1 <= rd_w_hold;
        mem_result_p1 <= sh_result;
      end
    end
  end

  assign bus.execute_memory_v      = mem_v_p1;
  assign bus.execute_memory_pc     = mem_pc_p1;
  assign bus.execute_memory_rd     = mem_rd_p1;
  assign bus.execute_memory_rd_w_v = mem_rd_w_v_p1;
  assign bus.execute_memory_result = mem_result_p1;
  assign bus.execute_fetch_pc_w_v  = fetch_pc_w_v_p1;
  assign bus.execute_fetch_pc      = fetch_pc_p1;

endmodule
